// File: rtl/row_clear_engine_pkg.sv
// Shared definitions for the row clear engine: board geometry
// defaults and the controller state encoding.
package row_clear_engine_pkg;

  localparam int RC_BLOCKS_WIDE = 10;
  localparam int RC_BLOCKS_HIGH = 20;
  localparam int RC_CNT_W       = 5;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_SCAN  = 2'd1,
    RC_SHIFT = 2'd2,
    RC_DONE  = 2'd3
  } rc_state_e;

endpackage

// File: rtl/row_clear_engine.sv
// Removes full rows from the settled board and collapses the rows above.
// Ports: clk, rst (sync, active-low), pause, start, board_in -> board_out,
// busy, done (1-cycle pulse), lines_cleared.
module row_clear_engine
  import row_clear_engine_pkg::*;
#(
  parameter int BLOCKS_WIDE = RC_BLOCKS_WIDE,
  parameter int BLOCKS_HIGH = RC_BLOCKS_HIGH,
  parameter int CNT_W       = RC_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pause,
  input  logic                           start,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_in,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_out,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               lines_cleared
);

  localparam int W  = BLOCKS_WIDE;
  localparam int H  = BLOCKS_HIGH;
  localparam int N  = W * H;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  rc_state_e state, state_d;

  logic [RW-1:0]    r, r_d;
  logic [N-1:0]     board_d, shifted;
  logic [CNT_W-1:0] lines_d;
  logic             busy_d, done_d;
  logic [H-1:0]     row_full;
  logic             cur_full;

  for (genvar y = 0; y < H; y++) begin : g_full
    assign row_full[y] = &board_out[y*W +: W];
  end

  assign cur_full = row_full[r];

  // Collapse: rows 1..r take the row above, row 0 becomes empty.
  always_comb begin
    shifted = board_out;
    shifted[0 +: W] = '0;
    for (int y = 1; y < H; y++) begin
      if (RW'(y) <= r)
        shifted[y*W +: W] = board_out[(y-1)*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= RC_IDLE;
    else if (!pause)
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      RC_IDLE: begin
        if (start)
          state_d = RC_SCAN;
      end
      RC_SCAN: begin
        if (cur_full)
          state_d = RC_SHIFT;
        else if (r == '0)
          state_d = RC_DONE;
      end
      RC_SHIFT: state_d = RC_SCAN;
      RC_DONE:  state_d = RC_IDLE;
      default:  state_d = RC_IDLE;
    endcase
  end

  always_comb begin
    board_d = board_out;
    lines_d = lines_cleared;
    r_d     = r;
    busy_d  = (state_d != RC_IDLE);
    done_d  = (state_d == RC_DONE);
    unique case (state)
      RC_IDLE: begin
        if (start) begin
          board_d = board_in;
          lines_d = '0;
          r_d     = RW'(H - 1);
        end
      end
      RC_SCAN: begin
        if (!cur_full && r != '0)
          r_d = r - RW'(1);
      end
      RC_SHIFT: begin
        board_d = shifted;
        lines_d = lines_cleared + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // A paused DONE drops the pulse; it is not replayed on resume.
  always_ff @(posedge clk) begin
    if (!rst) begin
      board_out     <= '0;
      lines_cleared <= '0;
      r             <= RW'(H - 1);
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (pause) begin
      done <= 1'b0;
    end else begin
      board_out     <= board_d;
      lines_cleared <= lines_d;
      r             <= r_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed bench for row_clear_engine with a row-compaction model
// checked every cycle plus literal latency/result expectations.
module tb_row_clear_engine;
  import row_clear_engine_pkg::*;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int N  = W * H;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pause = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  board_in = '0;
  logic [N-1:0]  board_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] lines_cleared;

  row_clear_engine #(
    .BLOCKS_WIDE(W),
    .BLOCKS_HIGH(H),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pause(pause),
    .start(start),
    .board_in(board_in),
    .board_out(board_out),
    .busy(busy),
    .done(done),
    .lines_cleared(lines_cleared)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Keep non-full rows in order, packed to the bottom of the board.
  function automatic void compact(input logic [N-1:0] b,
                                  output logic [N-1:0] o,
                                  output int k);
    int dst;
    logic [W-1:0] row;
    o = '0;
    k = 0;
    dst = H - 1;
    for (int y = H - 1; y >= 0; y--) begin
      row = b[y*W +: W];
      if (row == {W{1'b1}}) k++;
      else begin
        o[dst*W +: W] = row;
        dst--;
      end
    end
  endfunction

  function automatic logic [N-1:0] full_row(input int y);
    logic [N-1:0] m;
    m = '0;
    m[y*W +: W] = {W{1'b1}};
    return m;
  endfunction

  // Model: an operation lasts H+2k+1 unpaused edges after the accept.
  bit           m_en = 0;
  bit           active = 0;
  bit           adv = 0;
  int           progress = 0;
  int           lat = 0;
  int           res_k = 0;
  int           exp_lines = 0;
  logic [N-1:0] res_board = '0;
  logic [N-1:0] exp_board = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_en = 1;
      active = 0;
      adv = 0;
      exp_board = '0;
      exp_lines = 0;
    end else if (pause) begin
      adv = 0;
    end else if (!active && start) begin
      compact(board_in, res_board, res_k);
      lat = H + 2 * res_k + 1;
      active = 1;
      progress = 0;
      adv = 1;
    end else if (active) begin
      progress++;
      adv = 1;
      if (progress == lat) begin
        active = 0;
        exp_board = res_board;
        exp_lines = res_k;
      end
    end else begin
      adv = 0;
    end
  end

  always @(negedge clk) begin
    bit dexp;
    if (m_en) begin
      dexp = active && adv && (progress == lat - 1);
      chk("m_done", done, dexp);
      chk("m_busy", busy, active);
      if (dexp) begin
        chk("m_res_board", board_out, res_board);
        chk("m_res_lines", lines_cleared, res_k);
      end else if (!active) begin
        chk("m_idle_board", board_out, exp_board);
        chk("m_idle_lines", lines_cleared, exp_lines);
      end
    end
  end

  task automatic run_op(input string nm, input logic [N-1:0] b,
                        input int exp_lat, input int exp_k,
                        input logic [N-1:0] exp_b,
                        input int pause_at, input int start2_at);
    int cnt;
    int ndone;
    bit got;
    @(negedge clk);
    board_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    got = 0;
    while (cnt < 200) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      pause = (cnt >= pause_at && cnt < pause_at + 5);
      start = (cnt == start2_at);
      @(negedge clk);
      cnt++;
    end
    pause = 1'b0;
    start = 1'b0;
    chk({nm, "_seen"}, got, 1);
    chk({nm, "_lat"}, cnt, exp_lat);
    chk({nm, "_lines"}, lines_cleared, exp_k);
    chk({nm, "_board"}, board_out, exp_b);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk({nm, "_one_done"}, ndone, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  logic [N-1:0] b2, r2, b3, b4, r4;
  int nd;

  initial begin
    b2 = full_row(19);
    b2[3 + 18*W] = 1'b1;
    r2 = '0;
    r2[3 + 19*W] = 1'b1;
    b3 = full_row(16) | full_row(17) | full_row(18) | full_row(19);
    b4 = full_row(19) | full_row(17);
    b4[0 + 18*W] = 1'b1;
    r4 = '0;
    r4[0 + 19*W] = 1'b1;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_board", board_out, '0);
    chk("rst_lines", lines_cleared, 0);
    rst = 1'b1;

    run_op("empty", '0, 21, 0, '0, 1000, 1000);
    run_op("one", b2, 23, 1, r2, 1000, 1000);
    run_op("tetris", b3, 29, 4, '0, 1000, 1000);
    run_op("split", b4, 25, 2, r4, 1000, 1000);
    run_op("start2", b2, 23, 1, r2, 1000, 6);
    run_op("pause", b3, 34, 4, '0, 8, 1000);

    @(negedge clk);
    board_in = b4;
    start = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    chk("pause_start_busy", busy, 0);
    chk("pause_start_board", board_out, '0);

    @(negedge clk);
    board_in = b2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("shift_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_board", board_out, '0);
    chk("rst_mid_lines", lines_cleared, 0);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("rst_mid_no_done", nd, 0);

    run_op("after_rst", b2, 23, 1, r2, 1000, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
